// File: rtl/dm_unit_pkg.sv
// Shared definitions for the data-memory responder: access-type bit
// positions, FSM state encoding and latency bounds.
package dm_unit_pkg;

   // Bit positions inside the one-hot whb vector {LB,LBU,LH,LHU,LW,SB,SH,SW}
   localparam int unsigned WHB_LB  = 7;
   localparam int unsigned WHB_LBU = 6;
   localparam int unsigned WHB_LH  = 5;
   localparam int unsigned WHB_LHU = 4;
   localparam int unsigned WHB_LW  = 3;
   localparam int unsigned WHB_SB  = 2;
   localparam int unsigned WHB_SH  = 1;
   localparam int unsigned WHB_SW  = 0;

   // Legal request-to-done latency range
   localparam int unsigned LAT_MIN = 1;
   localparam int unsigned LAT_MAX = 4;

   // Latency counter width, sized to hold LAT_MAX-1
   localparam int unsigned CNT_W = $clog2(LAT_MAX);

   typedef enum logic [1:0] {
      DmIdle = 2'd0,
      DmBusy = 2'd1,
      DmDone = 2'd2
   } dm_state_e;

   // True when exactly one access-type bit is set
   function automatic logic whb_onehot(input logic [7:0] whb);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         n += 32'(whb[i]);
      end
      return (n == 1);
   endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational lane logic: little-endian byte/half/word steering for stores,
// sign/zero extension for loads, and access-legality checking.
module dm_lane
   import dm_unit_pkg::*;
(
   input  logic [7:0]  whb_i,
   input  logic        store_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] wd_i,
   input  logic [31:0] old_word_i,
   output logic [31:0] new_word_o,
   output logic [31:0] load_o,
   output logic        err_o
);

   logic        store_op;
   logic        half_op;
   logic        word_op;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Legality: one-hot type, type matches direction, natural alignment
   always_comb begin
      store_op = whb_i[WHB_SB] | whb_i[WHB_SH] | whb_i[WHB_SW];
      half_op  = whb_i[WHB_LH] | whb_i[WHB_LHU] | whb_i[WHB_SH];
      word_op  = whb_i[WHB_LW] | whb_i[WHB_SW];
      err_o    = !whb_onehot(whb_i)
               | (store_i != store_op)
               | (half_op & lane_i[0])
               | (word_op & (lane_i != 2'b00));
   end

   // Store merge: replicate the source across lanes, enable only the target bytes
   always_comb begin
      be    = 4'b0000;
      wdata = wd_i;
      if (whb_i[WHB_SB]) begin
         be    = 4'b0001 << lane_i;
         wdata = {4{wd_i[7:0]}};
      end else if (whb_i[WHB_SH]) begin
         be    = lane_i[1] ? 4'b1100 : 4'b0011;
         wdata = {2{wd_i[15:0]}};
      end else if (whb_i[WHB_SW]) begin
         be    = 4'b1111;
      end
      for (int i = 0; i < 4; i++) begin
         new_word_o[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word_i[8*i +: 8];
      end
   end

   // Load extraction and extension
   always_comb begin
      byte_v = old_word_i[{lane_i, 3'b000} +: 8];
      half_v = lane_i[1] ? old_word_i[31:16] : old_word_i[15:0];
      load_o = old_word_i;
      if (whb_i[WHB_LB]) begin
         load_o = {{24{byte_v[7]}}, byte_v};
      end else if (whb_i[WHB_LBU]) begin
         load_o = {24'h000000, byte_v};
      end else if (whb_i[WHB_LH]) begin
         load_o = {{16{half_v[15]}}, half_v};
      end else if (whb_i[WHB_LHU]) begin
         load_o = {16'h0000, half_v};
      end
   end

endmodule

// File: rtl/dm_unit.sv
// Data-memory responder: accepts one-cycle load/store requests, completes
// them after LATENCY cycles with a done pulse, registered load data and a
// misalignment flag.
module dm_unit
   import dm_unit_pkg::*;
#(
   parameter int unsigned DEPTH_W = 10,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   input  logic        MemWr,
   input  logic        MemRd,
   input  logic [7:0]  whb,
   output logic [31:0] rd,
   output logic        done,
   output logic        busy,
   output logic        misalign
);

   // Out-of-range latency settings are clamped into the legal window
   localparam int unsigned LatEff = (LATENCY < LAT_MIN) ? LAT_MIN :
                                    (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
   localparam int unsigned Words  = 2 ** DEPTH_W;

   dm_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DEPTH_W-1:0] word_q, word_d;
   logic [1:0]         lane_q, lane_d;
   logic [31:0]        wd_q, wd_d;
   logic [7:0]         whb_q, whb_d;
   logic               store_q, store_d;
   logic [31:0]        rd_q, rd_d;
   logic               done_q, done_d;
   logic               misalign_q, misalign_d;

   logic [31:0]        mem_q [Words];
   logic [31:0]        old_word;
   logic [31:0]        new_word;
   logic [31:0]        load_val;
   logic               lane_err;
   logic               mem_we;

   // Upper address bits are ignored so accesses wrap modulo memory size
   logic               unused_addr_hi;
   assign unused_addr_hi = ^addr[31:DEPTH_W+2];

   assign old_word = mem_q[word_q];

   dm_lane u_lane (
      .whb_i      (whb_q),
      .store_i    (store_q),
      .lane_i     (lane_q),
      .wd_i       (wd_q),
      .old_word_i (old_word),
      .new_word_o (new_word),
      .load_o     (load_val),
      .err_o      (lane_err)
   );

   // Next-state: request capture, latency countdown, completion
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      lane_d     = lane_q;
      wd_d       = wd_q;
      whb_d      = whb_q;
      store_d    = store_q;
      rd_d       = rd_q;
      done_d     = 1'b0;
      misalign_d = misalign_q;
      mem_we     = 1'b0;
      unique case (state_q)
         DmIdle: begin
            if (MemWr || MemRd) begin
               word_d  = addr[DEPTH_W+1:2];
               lane_d  = addr[1:0];
               wd_d    = wd;
               whb_d   = whb;
               // A simultaneous read and write is handled as a store
               store_d = MemWr;
               cnt_d   = CNT_W'(LatEff - 1);
               state_d = (LatEff > 1) ? DmBusy : DmDone;
            end
         end
         DmBusy: begin
            // Leave on the edge that brings the count to zero
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DmDone;
            end
         end
         DmDone: begin
            done_d     = 1'b1;
            misalign_d = lane_err;
            mem_we     = store_q & ~lane_err;
            if (!store_q && !lane_err) begin
               rd_d = load_val;
            end
            state_d = DmIdle;
         end
         default: state_d = DmIdle;
      endcase
   end

   // Control and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= DmIdle;
         cnt_q      <= '0;
         word_q     <= '0;
         lane_q     <= '0;
         wd_q       <= '0;
         whb_q      <= '0;
         store_q    <= 1'b0;
         rd_q       <= '0;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         lane_q     <= lane_d;
         wd_q       <= wd_d;
         whb_q      <= whb_d;
         store_q    <= store_d;
         rd_q       <= rd_d;
         done_q     <= done_d;
         misalign_q <= misalign_d;
      end
   end

   // Memory array: never cleared; a reset edge suppresses an in-flight write
   always_ff @(posedge clk) begin
      if (!reset && mem_we) begin
         mem_q[word_q] <= new_word;
      end
   end

   assign rd       = rd_q;
   assign done     = done_q;
   assign busy     = (state_q != DmIdle);
   assign misalign = misalign_q;

endmodule

// File: tb/tb_dm_unit.sv
// Scoreboard bench for dm_unit: one instance at LATENCY=1, one at LATENCY=3.
module tb_dm_unit;

   localparam logic [7:0] LB  = 8'h80;
   localparam logic [7:0] LBU = 8'h40;
   localparam logic [7:0] LH  = 8'h20;
   localparam logic [7:0] LHU = 8'h10;
   localparam logic [7:0] LW  = 8'h08;
   localparam logic [7:0] SB  = 8'h04;
   localparam logic [7:0] SH  = 8'h02;
   localparam logic [7:0] SW  = 8'h01;

   logic        clk = 1'b0;
   logic        reset_s [2];
   logic [31:0] addr_s  [2];
   logic [31:0] wd_s    [2];
   logic        wr_s    [2];
   logic        rdr_s   [2];
   logic [7:0]  whb_s   [2];
   logic [31:0] rd_s    [2];
   logic        done_s  [2];
   logic        busy_s  [2];
   logic        mis_s   [2];

   typedef struct {
      logic [31:0] rd;
      logic        mis;
      int          due;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dm_unit #(.DEPTH_W(10), .LATENCY(1)) u_lat1 (
      .clk      (clk),
      .reset    (reset_s[0]),
      .addr     (addr_s[0]),
      .wd       (wd_s[0]),
      .MemWr    (wr_s[0]),
      .MemRd    (rdr_s[0]),
      .whb      (whb_s[0]),
      .rd       (rd_s[0]),
      .done     (done_s[0]),
      .busy     (busy_s[0]),
      .misalign (mis_s[0])
   );

   dm_unit #(.DEPTH_W(10), .LATENCY(3)) u_lat3 (
      .clk      (clk),
      .reset    (reset_s[1]),
      .addr     (addr_s[1]),
      .wd       (wd_s[1]),
      .MemWr    (wr_s[1]),
      .MemRd    (rdr_s[1]),
      .whb      (whb_s[1]),
      .rd       (rd_s[1]),
      .done     (done_s[1]),
      .busy     (busy_s[1]),
      .misalign (mis_s[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
      end
   endtask

   // Monitor side: pop one expectation per observed done pulse
   task automatic mon(input int u);
      exp_t e;
      int   sz;
      sz = (u == 0) ? sb0.size() : sb1.size();
      if (sz == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL u%0d unexpected done at cycle %0d: got done=1, want done=0", u, cyc);
      end else begin
         if (u == 0) e = sb0.pop_front();
         else        e = sb1.pop_front();
         check($sformatf("u%0d rd", u), rd_s[u], e.rd);
         check($sformatf("u%0d misalign", u), 32'(mis_s[u]), 32'(e.mis));
         check($sformatf("u%0d done cycle", u), 32'(cyc), 32'(e.due));
      end
   endtask

   always @(negedge clk) if (done_s[0]) mon(0);
   always @(negedge clk) if (done_s[1]) mon(1);

   // Present a one-cycle request; returns at the following falling edge
   task automatic drive(input int u, input bit w, input bit r, input logic [7:0] t,
                        input logic [31:0] a, input logic [31:0] d);
      addr_s[u] = a;
      wd_s[u]   = d;
      whb_s[u]  = t;
      wr_s[u]   = w;
      rdr_s[u]  = r;
      @(negedge clk);
      wr_s[u]   = 1'b0;
      rdr_s[u]  = 1'b0;
   endtask

   // Stimulus side: push the expected completion, issue, wait out the latency
   task automatic xfer(input int u, input bit w, input bit r, input logic [7:0] t,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input bit emis);
      exp_t e;
      int   lat;
      lat   = (u == 0) ? 1 : 3;
      e.rd  = erd;
      e.mis = emis;
      e.due = cyc + 1 + lat;
      if (u == 0) sb0.push_back(e);
      else        sb1.push_back(e);
      drive(u, w, r, t, a, d);
      repeat (lat) @(negedge clk);
   endtask

   initial begin
      exp_t e;
      for (int u = 0; u < 2; u++) begin
         reset_s[u] = 1'b1;
         addr_s[u]  = '0;
         wd_s[u]    = '0;
         wr_s[u]    = 1'b0;
         rdr_s[u]   = 1'b0;
         whb_s[u]   = '0;
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d reset rd", u), rd_s[u], 32'h0);
         check($sformatf("u%0d reset done", u), 32'(done_s[u]), 32'h0);
         check($sformatf("u%0d reset busy", u), 32'(busy_s[u]), 32'h0);
         check($sformatf("u%0d reset misalign", u), 32'(mis_s[u]), 32'h0);
      end
      reset_s[0] = 1'b0;
      reset_s[1] = 1'b0;

      // LATENCY=1: lane steering, extension, misalignment, whb legality, wrap
      xfer(0, 1, 0, SW,  32'h10,   32'h11223344, 32'h00000000, 0);
      xfer(0, 0, 1, LW,  32'h10,   32'h0,        32'h11223344, 0);
      xfer(0, 1, 0, SB,  32'h11,   32'hAA,       32'h11223344, 0);
      xfer(0, 0, 1, LW,  32'h10,   32'h0,        32'h1122AA44, 0);
      xfer(0, 0, 1, LB,  32'h11,   32'h0,        32'hFFFFFFAA, 0);
      xfer(0, 0, 1, LBU, 32'h11,   32'h0,        32'h000000AA, 0);
      xfer(0, 1, 0, SH,  32'h12,   32'h8001,     32'h000000AA, 0);
      xfer(0, 0, 1, LH,  32'h12,   32'h0,        32'hFFFF8001, 0);
      xfer(0, 0, 1, LHU, 32'h12,   32'h0,        32'h00008001, 0);
      xfer(0, 0, 1, LW,  32'h10,   32'h0,        32'h8001AA44, 0);
      xfer(0, 0, 1, LW,  32'h13,   32'h0,        32'h8001AA44, 1);
      xfer(0, 1, 0, SH,  32'h11,   32'h5555,     32'h8001AA44, 1);
      xfer(0, 0, 1, LW,  32'h10,   32'h0,        32'h8001AA44, 0);
      xfer(0, 0, 1, LB,  32'h13,   32'h0,        32'hFFFFFF80, 0);
      xfer(0, 0, 1, LB,  32'h12,   32'h0,        32'h00000001, 0);
      xfer(0, 0, 1, LHU, 32'h10,   32'h0,        32'h0000AA44, 0);
      xfer(0, 0, 1, LW,  32'h1010, 32'h0,        32'h8001AA44, 0);
      xfer(0, 0, 1, SW,  32'h10,   32'h0,        32'h8001AA44, 1);
      xfer(0, 0, 1, 8'h00, 32'h10, 32'h0,        32'h8001AA44, 1);
      xfer(0, 0, 1, 8'h28, 32'h10, 32'h0,        32'h8001AA44, 1);
      xfer(0, 1, 1, SW,  32'h20,   32'hCAFEF00D, 32'h8001AA44, 0);
      xfer(0, 0, 1, LW,  32'h20,   32'h0,        32'hCAFEF00D, 0);
      xfer(0, 1, 0, LW,  32'h20,   32'h0,        32'hCAFEF00D, 1);
      xfer(0, 0, 1, LW,  32'h20,   32'h0,        32'hCAFEF00D, 0);

      // LATENCY=3: busy window and a store ignored while busy
      xfer(1, 1, 0, SW, 32'h40, 32'hDEADBEEF, 32'h00000000, 0);
      e.rd  = 32'hDEADBEEF;
      e.mis = 1'b0;
      e.due = cyc + 4;
      sb1.push_back(e);
      drive(1, 0, 1, LW, 32'h40, 32'h0);
      check("u1 busy cycle 1", 32'(busy_s[1]), 32'h1);
      drive(1, 1, 0, SW, 32'h40, 32'h0);
      check("u1 busy cycle 2", 32'(busy_s[1]), 32'h1);
      @(negedge clk);
      check("u1 busy cycle 3", 32'(busy_s[1]), 32'h1);
      @(negedge clk);
      check("u1 busy after done", 32'(busy_s[1]), 32'h0);
      xfer(1, 0, 1, LW, 32'h40, 32'h0, 32'hDEADBEEF, 0);

      // LATENCY=3: reset one cycle after a store abandons it
      drive(1, 1, 0, SW, 32'h40, 32'h12345678);
      check("u1 busy before reset", 32'(busy_s[1]), 32'h1);
      reset_s[1] = 1'b1;
      @(negedge clk);
      reset_s[1] = 1'b0;
      check("u1 busy after reset", 32'(busy_s[1]), 32'h0);
      check("u1 done after reset", 32'(done_s[1]), 32'h0);
      repeat (5) @(negedge clk);
      xfer(1, 0, 1, LW, 32'h40, 32'h0, 32'hDEADBEEF, 0);

      // Bounded drain of outstanding expectations
      for (int i = 0; i < 20 && (sb0.size() + sb1.size()) > 0; i++) begin
         @(negedge clk);
      end
      check("scoreboard drained", 32'(sb0.size() + sb1.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data-memory responder for the multicycle MIPS datapath; the memory-side end of the controller's MemWr / whb access interface.
- Accepts a one-cycle load or store request carrying a one-hot access-type vector. Performs byte/half/word lane steering, little-endian.
- Returns extended load data in a registered data register after a configurable latency, with a done pulse and an alignment-error flag.
- Sits between the ALU-output address register and the DR/write-back mux.

Parameters:
- DEPTH_W, 10: log2 of memory depth in 32-bit words (1024 words).
- LATENCY, 1: cycles from request acceptance to done. Legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address. Bits [DEPTH_W+1:2] select the word; [1:0] select the lane.
- wd  in  32  store data. Byte/half taken from the low bits.
- MemWr  in  1  store request, one cycle wide.
- MemRd  in  1  load request, one cycle wide.
- whb  in  8  one-hot access type {LB,LBU,LH,LHU,LW,SB,SH,SW}.
- rd  out  32  registered load result (the DR value).
- done  out  1  one-cycle pulse when an accepted request completes.
- busy  out  1  high while a request is in flight.
- misalign  out  1  high with done when the completed request was misaligned.

Behaviour:
- Reset: rd=0, done=0, busy=0, misalign=0, FSM=IDLE, latency counter=0. Memory contents are not cleared.
- FSM states:
  - IDLE: a request is accepted when (MemWr|MemRd) is high. The unit latches addr, wd, whb and the direction, loads cnt=LATENCY-1, then goes to BUSY if LATENCY>1, else to DONE.
  - BUSY: cnt decrements each cycle. At cnt==0 the unit goes to DONE.
  - DONE: the access is performed on this edge. done=1 for exactly one cycle. Returns to IDLE.
- busy=1 in BUSY and DONE. Requests arriving while busy=1 are ignored, with no queueing.
- Total latency: done asserts LATENCY cycles after the request cycle. With LATENCY=1, a request at edge N gives done and rd valid after edge N+1.
- Simultaneous MemWr and MemRd: treated as a store. The read is dropped.
- Whb rule: whb with zero or more than one bit set, or a load bit with MemWr (or a store bit with MemRd), completes with done=1 and misalign=1. There is no memory write and rd is unchanged.
- Alignment rule: a misaligned access completes with done=1 and misalign=1, with no write and no rd update. Misaligned means:
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]!=0.
- Store lanes, little-endian:
  - SB writes byte addr[1:0] from wd[7:0].
  - SH writes bytes {addr[1],0} and {addr[1],1} from wd[15:0].
  - SW writes all four bytes.
  - Other bytes of the word are preserved.
- Load extraction:
  - LB/LBU select byte addr[1:0], sign- or zero-extended to 32 bits.
  - LH/LHU select the half at addr[1], sign- or zero-extended.
  - LW returns the full word.
- rd holds its value until the next successful load. Stores never change rd.
- Address bits above DEPTH_W+1 are ignored, so addresses wrap modulo memory size.
- misalign is cleared at the next done or at reset.
- Reset mid-operation: the in-flight request is abandoned. No memory write occurs, done stays 0, and the FSM goes to IDLE on the reset edge.

Decomposition:
- Shared header (existing head.v):
  - whb bit-index constants (WHB_LB=7 … WHB_SW=0);
  - FSM state encodings DM_IDLE, DM_BUSY, DM_DONE;
  - LATENCY bounds.
- One sub-module, dm_lane: combinational unit holding the lane logic.
  - Store: given whb, addr[1:0], wd and the old word, produces the merged new word and misalign.
  - Load: given the read word, produces the extended load value.
  - dm_unit holds the memory array, FSM, counter and registers.

Test Plan:
- SW 0x11223344 to addr 0x10, then LW 0x10 (LATENCY=1). Required: done one cycle after each request, rd=0x11223344, misalign=0.
- SB wd=0xAA to 0x11, then LW 0x10. Required: rd=0x1122AA44. Then LB 0x11 gives rd=0xFFFFFFAA, and LBU 0x11 gives rd=0x000000AA.
- SH wd=0x8001 to 0x12, then LH 0x12 gives rd=0xFFFF8001, and LHU 0x12 gives rd=0x00008001. LW 0x10 gives rd=0x8001AA44.
- Misaligned accesses:
  - LW at 0x13 and SH at 0x11 each give done=1, misalign=1, rd unchanged.
  - A subsequent LW 0x10 still returns 0x8001AA44.
- LATENCY=3:
  - LW issued. Required: busy=1 for 3 cycles and done on the 3rd edge.
  - A second MemWr issued while busy must be ignored, so the memory word is unchanged.
- LATENCY=3: SW issued, then reset asserted one cycle later. Required: no write (the old word is read back), done never pulses, busy=0 after the reset edge.
